// File: rtl/spmv_seq_ctrl.sv
// spmv_seq_ctrl
// Sequencer for the sparse matrix-vector datapath. For each batch it reads
// IN_DEPTH activation words from the input BRAM. It then waits out the BRAM
// read latency plus the compute pipeline latency. Finally it writes OUT_DEPTH
// result words into the output BRAM. The address bases advance by one batch
// each time, so consecutive batches use consecutive address windows, and both
// bases wrap.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start, abort      job request (sampled in IDLE) and synchronous abort
//   num_batches       batch count, latched with start
//   busy, done        job-in-progress flag and one-cycle completion pulse
//   in_en/in_we/in_addr            input BRAM port (read only)
//   out_en/out_we/out_addr         output BRAM port
//   out_valid, drv_en              result strobe and early result-driver enable
//   batch_idx                      index of the batch in progress
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start, all enables low
// LOAD  | reading IN_DEPTH input words, in_en high
// WAIT  | LOAD_LAT+PIPE_LAT cycles of BRAM + pipeline latency
// OUT   | writing OUT_DEPTH results, out_en/out_we/out_valid high
// DONE  | single cycle with done high, then back to IDLE
module spmv_seq_ctrl #(
   parameter int IN_DEPTH  = 64,
   parameter int IN_AW     = 8,
   parameter int LOAD_LAT  = 3,
   parameter int PIPE_LAT  = 16,
   parameter int OUT_DEPTH = 64,
   parameter int OUT_AW    = 11,
   parameter int DRV_LEAD  = 2,
   parameter int NB_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [NB_W-1:0]   num_batches,
   output logic              busy,
   output logic              done,
   output logic              in_en,
   output logic              in_we,
   output logic [IN_AW-1:0]  in_addr,
   output logic              out_en,
   output logic              out_we,
   output logic [OUT_AW-1:0] out_addr,
   output logic              out_valid,
   output logic              drv_en,
   output logic [NB_W-1:0]   batch_idx
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT, S_OUT, S_DONE
   } state_t;

   localparam int WAIT_LEN = LOAD_LAT + PIPE_LAT;
   localparam int MAX_LEN  = (IN_DEPTH > WAIT_LEN) ?
                             ((IN_DEPTH > OUT_DEPTH) ? IN_DEPTH : OUT_DEPTH) :
                             ((WAIT_LEN > OUT_DEPTH) ? WAIT_LEN : OUT_DEPTH);
   // Phase counter holds (remaining cycles - 1), so it never exceeds MAX_LEN-1.
   localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [CW-1:0] IN_LAST   = CW'(IN_DEPTH - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LEN - 1);
   localparam logic [CW-1:0] OUT_LAST  = CW'(OUT_DEPTH - 1);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NB_W-1:0]     nb_q, nb_d;
   logic [IN_AW-1:0]    in_base_q, in_base_d;
   logic [OUT_AW-1:0]   out_base_q, out_base_d;
   logic [NB_W-1:0]     batch_d;
   logic                zero_start;
   logic                busy_d, done_d, in_en_d, out_act_d, drv_d, out_act_q;
   logic [IN_AW-1:0]    in_addr_d;
   logic [OUT_AW-1:0]   out_addr_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      nb_d       = nb_q;
      in_base_d  = in_base_q;
      out_base_d = out_base_q;
      batch_d    = batch_idx;
      zero_start = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_batches != '0) begin
                  nb_d       = num_batches;
                  batch_d    = '0;
                  in_base_d  = '0;
                  out_base_d = '0;
                  state_d    = S_LOAD;
                  cnt_d      = IN_LAST;
               end else begin
                  zero_start = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (cnt_q == '0) begin
               state_d = S_WAIT;
               cnt_d   = WAIT_LAST;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_OUT;
               cnt_d   = OUT_LAST;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_OUT: begin
            if (cnt_q == '0) begin
               in_base_d  = in_base_q + IN_AW'(IN_DEPTH);
               out_base_d = out_base_q + OUT_AW'(OUT_DEPTH);
               if (({1'b0, batch_idx} + {{NB_W{1'b0}}, 1'b1}) < {1'b0, nb_q}) begin
                  batch_d = batch_idx + NB_W'(1);
                  state_d = S_LOAD;
                  cnt_d   = IN_LAST;
               end else begin
                  state_d = S_DONE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         in_base_d  = '0;
         out_base_d = '0;
         zero_start = 1'b0;
      end

      // Outputs are registered, so they are decoded from the next state.
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE) || zero_start;
      in_en_d   = (state_d == S_LOAD);
      out_act_d = (state_d == S_OUT);

      in_addr_d = in_addr;
      if (state_d == S_LOAD)
         in_addr_d = (state_q == S_LOAD) ? in_addr + IN_AW'(1) : in_base_d;

      out_addr_d = out_addr;
      if (state_d == S_OUT)
         out_addr_d = (state_q == S_OUT) ? out_addr + OUT_AW'(1) : out_base_d;

      // drv_en is the out_valid window shifted DRV_LEAD cycles earlier:
      // the last DRV_LEAD WAIT cycles plus all but the last DRV_LEAD OUT cycles.
      drv_d = ((state_d == S_WAIT) && (32'(cnt_d) + 1 <= DRV_LEAD) &&
               (32'(cnt_d) + OUT_DEPTH >= DRV_LEAD)) ||
              ((state_d == S_OUT) && (32'(cnt_d) + 1 > DRV_LEAD));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         nb_q       <= '0;
         in_base_q  <= '0;
         out_base_q <= '0;
         batch_idx  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         in_en      <= 1'b0;
         in_addr    <= '0;
         out_act_q  <= 1'b0;
         out_addr   <= '0;
         drv_en     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         nb_q       <= nb_d;
         in_base_q  <= in_base_d;
         out_base_q <= out_base_d;
         batch_idx  <= batch_d;
         busy       <= busy_d;
         done       <= done_d;
         in_en      <= in_en_d;
         in_addr    <= in_addr_d;
         out_act_q  <= out_act_d;
         out_addr   <= out_addr_d;
         drv_en     <= drv_d;
      end
   end

   assign in_we     = 1'b0;
   assign out_en    = out_act_q;
   assign out_we    = out_act_q;
   assign out_valid = out_act_q;

endmodule

// File: tb/tb_spmv_seq_ctrl.sv
// Testbench for spmv_seq_ctrl. The reference model turns every accepted job
// into a list of (cycle, address, batch) events, one list per output strobe.
// The monitor pops and compares those events whenever the DUT raises the
// strobe. A second instance with DRV_LEAD=0 checks the zero-lead case.
module tb_spmv_seq_ctrl;
   localparam int IN_DEPTH  = 5;
   localparam int IN_AW     = 3;
   localparam int LOAD_LAT  = 2;
   localparam int PIPE_LAT  = 3;
   localparam int OUT_DEPTH = 6;
   localparam int OUT_AW    = 4;
   localparam int DRV_LEAD  = 2;
   localparam int NB_W      = 3;
   localparam int WL        = LOAD_LAT + PIPE_LAT;
   localparam int P         = IN_DEPTH + WL + OUT_DEPTH;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic [NB_W-1:0] num_batches = '0;

   logic busy, done, in_en, in_we, out_en, out_we, out_valid, drv_en;
   logic [IN_AW-1:0]  in_addr;
   logic [OUT_AW-1:0] out_addr;
   logic [NB_W-1:0]   batch_idx;

   logic busy0, done0, in_en0, in_we0, out_en0, out_we0, out_valid0, drv_en0;
   logic [IN_AW-1:0]  in_addr0;
   logic [OUT_AW-1:0] out_addr0;
   logic [NB_W-1:0]   batch_idx0;

   spmv_seq_ctrl #(.IN_DEPTH(IN_DEPTH), .IN_AW(IN_AW), .LOAD_LAT(LOAD_LAT),
      .PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH), .OUT_AW(OUT_AW),
      .DRV_LEAD(DRV_LEAD), .NB_W(NB_W)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .num_batches(num_batches), .busy(busy), .done(done), .in_en(in_en),
      .in_we(in_we), .in_addr(in_addr), .out_en(out_en), .out_we(out_we),
      .out_addr(out_addr), .out_valid(out_valid), .drv_en(drv_en),
      .batch_idx(batch_idx));

   spmv_seq_ctrl #(.IN_DEPTH(IN_DEPTH), .IN_AW(IN_AW), .LOAD_LAT(LOAD_LAT),
      .PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH), .OUT_AW(OUT_AW),
      .DRV_LEAD(0), .NB_W(NB_W)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .num_batches(num_batches), .busy(busy0), .done(done0), .in_en(in_en0),
      .in_we(in_we0), .in_addr(in_addr0), .out_en(out_en0), .out_we(out_we0),
      .out_addr(out_addr0), .out_valid(out_valid0), .drv_en(drv_en0),
      .batch_idx(batch_idx0));

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int addr;
      int bidx;
   } ent_t;

   // 0: in_en, 1: out_valid, 2: drv_en, 3: drv_en of zero-lead instance, 4: done
   ent_t q[5][$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   busy_lo = 1;
   int   busy_hi = 0;
   bit   mon_on = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
   endtask

   task automatic mon(input int id, input logic fire, input int addr,
                      input int bidx, input bit use_data, input string nm);
      ent_t e;
      while (q[id].size() > 0 && q[id][0].cyc < cyc) begin
         n_checks++;
         $display("FAIL %s missing: got strobe 0 expected 1 (cycle %0d)", nm, q[id][0].cyc);
         void'(q[id].pop_front());
      end
      if (fire) begin
         if (q[id].size() > 0 && q[id][0].cyc == cyc) begin
            e = q[id].pop_front();
            if (use_data) begin
               chk({nm, "_addr"}, addr, e.addr);
               chk({nm, "_batch"}, bidx, e.bidx);
            end else begin
               chk(nm, 1, 1);
            end
         end else begin
            n_checks++;
            $display("FAIL %s unexpected: got strobe 1 expected 0 (cycle %0d)", nm, cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         int exp_o;
         int exp_o0;
         exp_o  = (q[1].size() > 0 && q[1][0].cyc == cyc) ? 1 : 0;
         exp_o0 = (q[3].size() > 0 && q[3][0].cyc == cyc) ? 1 : 0;
         chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
         chk("in_we", in_we, 0);
         chk("out_en", out_en, exp_o);
         chk("out_we", out_we, exp_o);
         chk("out_valid_lead0", out_valid0, exp_o0);
         mon(0, in_en, in_addr, batch_idx, 1'b1, "in");
         mon(1, out_valid, out_addr, batch_idx, 1'b1, "out");
         mon(2, drv_en, 0, 0, 1'b0, "drv");
         mon(3, drv_en0, 0, 0, 1'b0, "drv_lead0");
         mon(4, done, 0, 0, 1'b0, "done");
      end
   end

   // Reference model: a job accepted at edge s occupies s .. s+n*P.
   function automatic bit model_busy(input int c);
      return (c >= busy_lo && c <= busy_hi);
   endfunction

   task automatic model_start(input int s, input int n);
      ent_t e;
      if (model_busy(s - 1)) return;
      if (n == 0) begin
         e.cyc = s; e.addr = 0; e.bidx = 0;
         q[4].push_back(e);
         return;
      end
      for (int b = 0; b < n; b++) begin
         int bs;
         bs = s + b * P;
         for (int i = 0; i < IN_DEPTH; i++) begin
            e.cyc = bs + i; e.addr = (b * IN_DEPTH + i) % (1 << IN_AW); e.bidx = b;
            q[0].push_back(e);
         end
         for (int k = 0; k < OUT_DEPTH; k++) begin
            e.cyc = bs + IN_DEPTH + WL + k;
            e.addr = (b * OUT_DEPTH + k) % (1 << OUT_AW); e.bidx = b;
            q[1].push_back(e);
            q[3].push_back(e);
            e.cyc = bs + IN_DEPTH + WL - DRV_LEAD + k;
            q[2].push_back(e);
         end
      end
      e.cyc = s + n * P; e.addr = 0; e.bidx = 0;
      q[4].push_back(e);
      busy_lo = s;
      busy_hi = s + n * P;
   endtask

   // abort or reset sampled at edge a: nothing from cycle a onward survives
   task automatic model_abort(input int a);
      for (int id = 0; id < 5; id++) begin
         ent_t t[$];
         for (int j = 0; j < q[id].size(); j++)
            if (q[id][j].cyc < a) t.push_back(q[id][j]);
         q[id] = t;
      end
      if (model_busy(a - 1)) busy_hi = a - 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      num_batches = NB_W'(n);
      model_start(cyc + 1, n);
      tick();
      start = 1'b0;
      num_batches = NB_W'($urandom_range(0, 7));
   endtask

   task automatic do_abort();
      abort = 1'b1;
      model_abort(cyc + 1);
      tick();
      abort = 1'b0;
   endtask

   task automatic run_idle();
      while (cyc <= busy_hi + 1) tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_in_en"}, in_en, 0);
      chk({tag, "_in_addr"}, in_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_addr"}, out_addr, 0);
      chk({tag, "_drv_en"}, drv_en, 0);
      chk({tag, "_batch_idx"}, batch_idx, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int n;
      repeat (3) tick();
      chk_zero("reset");
      rst = 1'b0;
      mon_on = 1'b1;
      tick();

      // single batch, then three back-to-back batches with an ignored start
      do_start(1);
      run_idle();
      do_start(3);
      repeat (20) tick();
      do_start(5);
      run_idle();

      // zero batches: lone done pulse
      do_start(0);
      repeat (3) tick();

      // abort mid-OUT, then replay from address 0
      do_start(2);
      s = cyc;
      while (cyc < s + IN_DEPTH + WL + 2) tick();
      do_abort();
      repeat (3) tick();
      do_start(1);
      run_idle();

      // start and abort together: abort wins
      start = 1'b1; abort = 1'b1; num_batches = 3'd2;
      model_abort(cyc + 1);
      tick();
      start = 1'b0; abort = 1'b0;
      repeat (3) tick();

      // reset together with abort in the middle of batch 1 WAIT
      do_start(3);
      s = cyc;
      while (cyc < s + P + IN_DEPTH + 1) tick();
      rst = 1'b1; abort = 1'b1;
      model_abort(cyc + 1);
      tick();
      chk_zero("rst_wait");
      rst = 1'b0; abort = 1'b0;
      repeat (2) tick();
      do_start(2);
      run_idle();

      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(0, 7);
         do_start(n);
         if (n > 0 && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, n * P)) tick();
            do_abort();
         end else begin
            while (cyc <= busy_hi) begin
               if ($urandom_range(0, 15) == 0) do_start($urandom_range(0, 7));
               else tick();
            end
         end
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (5) tick();
      for (int id = 0; id < 5; id++) chk("drain", q[id].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
